// File: rtl/coordinated_step_generator.sv
// Multi-axis coordinated stepper pulse generator.
// All axes share one major-axis tick stream. Each axis uses Bresenham/DDA
// accumulation, so every axis starts on the first tick and finishes on the last.
// Outputs are registered. The tick decision is made on the edge that enters the
// tick cycle, so a step pulse is visible during the tick cycle itself.
module coordinated_step_generator #(
    parameter int NUM_AXES  = 2,
    parameter int STEP_W    = 8,
    parameter int DIV_W     = 16,
    parameter int PULSE_W   = 2,
    parameter int DIR_SETUP = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         new_in,
    input  logic [NUM_AXES*STEP_W-1:0]   num_steps,
    input  logic [NUM_AXES-1:0]          direction,
    input  logic [DIV_W-1:0]             step_period,
    input  logic                         enable,
    input  logic                         abort,
    output logic                         ready,
    output logic                         done,
    output logic                         aborted,
    output logic [NUM_AXES-1:0]          step,
    output logic [NUM_AXES-1:0]          dir,
    output logic [NUM_AXES*STEP_W-1:0]   steps_out
);
    localparam int PC_W = $clog2(PULSE_W + 1);
    localparam int SC_W = $clog2(DIR_SETUP + 1);
    localparam logic [DIV_W-1:0] MIN_P = DIV_W'(2 * PULSE_W);

    typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

    state_t                           state;
    logic [NUM_AXES-1:0][STEP_W-1:0]  n_in;
    logic [NUM_AXES-1:0][STEP_W-1:0]  n_q;
    logic [NUM_AXES-1:0][STEP_W:0]    acc;
    logic [NUM_AXES-1:0][STEP_W:0]    sum;
    logic [NUM_AXES-1:0][STEP_W:0]    acc_nxt;
    logic [NUM_AXES-1:0][STEP_W-1:0]  cnt;
    logic [NUM_AXES-1:0]              hit;
    logic [STEP_W-1:0]                major, major_in, tick_idx;
    logic [DIV_W-1:0]                 period, p_in, phase;
    logic [SC_W-1:0]                  setup_cnt;
    logic [PC_W-1:0]                  pulse_cnt;
    logic                             setup_last, period_last, last_tick, tick_go;

    assign n_in      = num_steps;
    assign steps_out = cnt;

    // Command decode: major-axis length and clamped period
    always_comb begin
        major_in = '0;
        for (int i = 0; i < NUM_AXES; i++)
            if (n_in[i] > major_in) major_in = n_in[i];
        p_in = (step_period < MIN_P) ? MIN_P : step_period;
    end

    // Next tick qualification and per-axis DDA step decision
    always_comb begin
        setup_last  = (setup_cnt == SC_W'(DIR_SETUP - 1));
        period_last = (phase == period - DIV_W'(1));
        last_tick   = (tick_idx == major - STEP_W'(1));
        tick_go     = enable && !abort &&
                      ((state == SETUP && setup_last) ||
                       (state == RUN && period_last && !last_tick));
        sum     = '0;
        acc_nxt = acc;
        hit     = '0;
        for (int i = 0; i < NUM_AXES; i++) begin
            sum[i] = acc[i] + {1'b0, n_q[i]};
            if (sum[i] >= {1'b0, major}) begin
                hit[i]     = 1'b1;
                acc_nxt[i] = sum[i] - {1'b0, major};
            end else begin
                acc_nxt[i] = sum[i];
            end
        end
    end

    // Move sequencer, step pulse timer and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ready     <= 1'b1;
            done      <= 1'b0;
            aborted   <= 1'b0;
            step      <= '0;
            dir       <= '0;
            cnt       <= '0;
            acc       <= '0;
            n_q       <= '0;
            major     <= '0;
            period    <= '0;
            phase     <= '0;
            tick_idx  <= '0;
            setup_cnt <= '0;
            pulse_cnt <= '0;
        end else begin
            done <= 1'b0;
            // pulse width runs on wall-clock cycles, independent of pause
            if (pulse_cnt != '0) pulse_cnt <= pulse_cnt - PC_W'(1);
            else                 step      <= '0;
            case (state)
                IDLE: if (new_in) begin
                    n_q       <= n_in;
                    major     <= major_in;
                    period    <= p_in;
                    dir       <= direction;
                    cnt       <= '0;
                    acc       <= '0;
                    aborted   <= 1'b0;
                    setup_cnt <= '0;
                    phase     <= '0;
                    tick_idx  <= '0;
                    ready     <= 1'b0;
                    if (major_in == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= SETUP;
                    end
                end
                SETUP, RUN: begin
                    if (abort) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        aborted   <= 1'b1;
                        step      <= '0;
                        pulse_cnt <= '0;
                    end else if (enable) begin
                        if (state == SETUP) begin
                            if (setup_last) begin
                                state    <= RUN;
                                phase    <= '0;
                                tick_idx <= '0;
                            end else begin
                                setup_cnt <= setup_cnt + SC_W'(1);
                            end
                        end else if (period_last) begin
                            phase <= '0;
                            if (last_tick) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                tick_idx <= tick_idx + STEP_W'(1);
                            end
                        end else begin
                            phase <= phase + DIV_W'(1);
                        end
                        if (tick_go) begin
                            step      <= hit;
                            pulse_cnt <= PC_W'(PULSE_W - 1);
                            acc       <= acc_nxt;
                            for (int i = 0; i < NUM_AXES; i++)
                                cnt[i] <= cnt[i] + STEP_W'(hit[i]);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_coordinated_step_generator.sv
// Scoreboard bench for coordinated_step_generator.
// The stimulus side predicts each move from closed-form rules (tick times from an
// active-cycle count, per-axis pulses from floor((k+1)*n/major)) and queues the
// prediction. A monitor accumulates the observed pulses and checks them at each done.
module tb_coordinated_step_generator;
    localparam int NA = 2, SW = 8, DW = 16, PW = 2, DS = 2;

    logic clk = 0, reset = 1, new_in = 0, enable = 1, abort = 0;
    logic [NA*SW-1:0] num_steps = '0;
    logic [NA-1:0]    direction = '0;
    logic [DW-1:0]    step_period = '0;
    logic             ready, done, aborted;
    logic [NA-1:0]    step, dir;
    logic [NA*SW-1:0] steps_out;

    int cyc = 0, n_cmp = 0, n_bad = 0;

    typedef struct {
        int          done_cyc;
        bit          abrt;
        logic [NA-1:0] dirv;
        int          nst[NA];
        int          rises[NA];
        int          highs[NA];
        longint      rsum[NA];
    } exp_t;
    exp_t sb[$];

    coordinated_step_generator #(.NUM_AXES(NA), .STEP_W(SW), .DIV_W(DW),
                                 .PULSE_W(PW), .DIR_SETUP(DS)) dut (
        .clk(clk), .reset(reset), .new_in(new_in), .num_steps(num_steps),
        .direction(direction), .step_period(step_period), .enable(enable),
        .abort(abort), .ready(ready), .done(done), .aborted(aborted),
        .step(step), .dir(dir), .steps_out(steps_out));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, longint act, longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference: move timeline from the pause window and abort offset
    function automatic exp_t model(input int n0, input int n1, input int per,
                                   input logic [NA-1:0] dv, input int ab,
                                   input int ps, input int pl, input int t0);
        exp_t e;
        int n[NA];
        int major, p, j, c, k;
        int tc[$];
        n[0] = n0; n[1] = n1;
        major = (n0 > n1) ? n0 : n1;
        p = (per < 2*PW) ? 2*PW : per;
        e.abrt = 0; e.dirv = dv;
        if (major == 0) begin
            e.done_cyc = t0 + 1;
        end else begin
            j = 0; c = t0 + 1; k = 0;
            while (c < t0 + 100000) begin
                if (k < major && j == DS + k*p) begin tc.push_back(c); k++; end
                if (j == DS + major*p) begin e.done_cyc = c; break; end
                if (ab != 0 && c - t0 == ab) begin e.done_cyc = c + 1; e.abrt = 1; break; end
                if (!((c - t0) >= ps && (c - t0) < ps + pl)) j++;
                c++;
            end
        end
        for (int i = 0; i < NA; i++) begin
            e.rises[i] = 0; e.highs[i] = 0; e.rsum[i] = 0;
            e.nst[i] = (major == 0) ? 0 : (tc.size() * n[i]) / major;
            for (int t = 0; t < tc.size(); t++)
                if (((t+1)*n[i]) / major > (t*n[i]) / major) begin
                    e.rises[i]++;
                    e.rsum[i] += tc[t];
                    e.highs[i] += (e.done_cyc - tc[t] < PW) ? e.done_cyc - tc[t] : PW;
                end
        end
        return e;
    endfunction

    // Monitor: accumulate pulses, compare against the queued prediction on done
    initial begin : monitor
        int rises[NA], highs[NA];
        longint rsum[NA];
        logic [NA-1:0] prev;
        bit was_rst, chk_rdy;
        exp_t e;
        prev = '0; was_rst = 0; chk_rdy = 0;
        for (int i = 0; i < NA; i++) begin rises[i] = 0; highs[i] = 0; rsum[i] = 0; end
        forever begin
            @(negedge clk);
            if (was_rst) begin
                check("rst_ready", ready, 1);
                check("rst_done", done, 0);
                check("rst_aborted", aborted, 0);
                check("rst_step", step, 0);
                check("rst_dir", dir, 0);
                check("rst_steps_out", steps_out, 0);
            end
            if (chk_rdy) check("ready_after_done", ready, 1);
            chk_rdy = 0;
            if (reset) begin
                was_rst = 1; prev = '0;
                for (int i = 0; i < NA; i++) begin rises[i] = 0; highs[i] = 0; rsum[i] = 0; end
            end else begin
                was_rst = 0;
                for (int i = 0; i < NA; i++)
                    if (step[i]) begin
                        highs[i]++;
                        if (!prev[i]) begin rises[i]++; rsum[i] += cyc; end
                    end
                prev = step;
                if (done) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_done: done=1 at cycle %0d with no move outstanding", cyc);
                    end else begin
                        e = sb.pop_front();
                        check("done_cycle", cyc, e.done_cyc);
                        check("aborted", aborted, e.abrt);
                        check("dir", dir, e.dirv);
                        for (int i = 0; i < NA; i++) begin
                            check($sformatf("steps_out[%0d]", i), steps_out[i*SW +: SW], e.nst[i]);
                            check($sformatf("pulses[%0d]", i), rises[i], e.rises[i]);
                            check($sformatf("high_cycles[%0d]", i), highs[i], e.highs[i]);
                            check($sformatf("pulse_times[%0d]", i), rsum[i], e.rsum[i]);
                        end
                    end
                    for (int i = 0; i < NA; i++) begin rises[i] = 0; highs[i] = 0; rsum[i] = 0; end
                    chk_rdy = 1;
                end
            end
        end
    end

    // Entered and left at posedge+1; waits for ready, issues one command, drives the move
    task automatic run_move(input int n0, input int n1, input int per,
                            input logic [NA-1:0] dv, input int ab,
                            input int ps, input int pl);
        exp_t e;
        int w, t0;
        w = 0;
        while (!ready) begin
            @(posedge clk); #1; w++;
            if (w > 500) begin
                n_cmp++; n_bad++;
                $display("FAIL ready_timeout: ready still 0 after %0d cycles", w);
                return;
            end
        end
        t0 = cyc;
        new_in = 1; num_steps = {SW'(n1), SW'(n0)}; direction = dv;
        step_period = DW'(per);
        abort = ($urandom % 4 == 0);      // abort while idle has no effect
        enable = $urandom % 2;
        e = model(n0, n1, per, dv, ab, ps, pl, t0);
        sb.push_back(e);
        for (int o = 1; o <= e.done_cyc - t0; o++) begin
            @(posedge clk); #1;
            new_in = ($urandom % 8 == 0);  // ignored while busy
            if (new_in) begin
                num_steps = NA*SW'($urandom); direction = NA'($urandom);
                step_period = DW'($urandom);
            end
            enable = !(o >= ps && o < ps + pl);
            abort  = (ab != 0 && o == ab);
        end
        @(posedge clk); #1;
        new_in = 0; abort = 0; enable = 1;
    endtask

    task automatic reset_mid_run();
        int w;
        w = 0;
        while (!ready && w < 500) begin @(posedge clk); #1; w++; end
        new_in = 1; num_steps = {SW'(5), SW'(10)}; direction = 2'b11; step_period = 4;
        repeat (20) begin @(posedge clk); #1; new_in = 0; end
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int n0, n1, per, ab, ps, pl, w;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        run_move(10, 5, 4, 2'b01, 0, 0, 0);        // basic 2:1 ratio
        run_move(0, 7, 4, 2'b10, 0, 0, 0);         // axis0 idle
        run_move(0, 0, 4, 2'b11, 0, 0, 0);         // empty move
        run_move(3, 3, 1, 2'b00, 0, 0, 0);         // period clamps up
        run_move(10, 5, 4, 2'b01, 15, 0, 0);       // abort on a tick cycle
        run_move(10, 5, 4, 2'b01, 0, 10, 5);       // pause mid-period
        run_move(255, 254, 2, 2'b10, 0, 0, 0);     // full-width counts
        run_move(6, 4, 5, 2'b01, 2, 0, 0);         // abort during setup
        run_move(1, 9, 0, 2'b11, 0, 1, 3);         // pause during setup
        for (int m = 0; m < 30; m++) begin
            n0  = ($urandom % 5 == 0) ? 0 : $urandom_range(1, 40);
            n1  = ($urandom % 5 == 0) ? 0 : $urandom_range(1, 40);
            per = $urandom_range(0, 7);
            ab  = ($urandom % 4 == 0) ? $urandom_range(1, 80) : 0;
            ps  = 0; pl = 0;
            if ($urandom % 2 == 0) begin ps = $urandom_range(1, 40); pl = $urandom_range(1, 8); end
            run_move(n0, n1, per, NA'($urandom), ab, ps, pl);
        end
        reset_mid_run();
        run_move(4, 2, 4, 2'b01, 0, 0, 0);         // clean move after reset
        w = 0;
        while (sb.size() != 0 && w < 200) begin @(posedge clk); #1; w++; end
        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d moves never reported done, expected 0", sb.size());
        end
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/coordinated_step_generator.md
Name: coordinated_step_generator

Overview:
Multi-axis stepper pulse generator. It replaces per-joint stepper_motor instances and the ad-hoc step_scale ratio logic with a single block that uses Bresenham/DDA interpolation, so all NUM_AXES joints start together and finish on the same tick. It sits between ScaraController (steps/dir/dataReady/stepperReady handshake) and the stepper driver pins. It adds direction setup time, pause, abort and per-axis step counters.

Parameters:
NUM_AXES, 2, number of coordinated axes (>=1)
STEP_W, 8, width of per-axis step count
DIV_W, 16, width of step_period
PULSE_W, 2, step pulse high time in clocks (>=1)
DIR_SETUP, 2, clocks between dir update and first tick (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
new_in  in  1  command strobe; accepted only when ready=1
num_steps  in  NUM_AXES*STEP_W  per-axis step counts; axis i at [i*STEP_W +: STEP_W]
direction  in  NUM_AXES  per-axis direction
step_period  in  DIV_W  clocks per major-axis tick
enable  in  1  0 = pause
abort  in  1  terminate current move
ready  out  1  idle, can accept a command
done  out  1  one-cycle pulse at move end
aborted  out  1  last move ended by abort
step  out  NUM_AXES  step pulses
dir  out  NUM_AXES  registered direction
steps_out  out  NUM_AXES*STEP_W  pulses emitted per axis in the current/last move

Behaviour:
- Reset (sync, active-high): state IDLE, ready=1, done=0, aborted=0, step=0, dir=0, steps_out=0, accumulators=0. Reset mid-move kills the move immediately, including any step pulse in flight.
- States: IDLE, SETUP, RUN, DONE.
- IDLE: ready=1. new_in=1 at cycle T latches num_steps, direction and P. P = max(step_period, 2*PULSE_W). The same edge also does the following:
  - clears steps_out, accumulators and aborted;
  - sets major = max over i of num_steps[i];
  - sets dir = direction at T+1.
  - If major=0, go to DONE; otherwise go to SETUP.
  - new_in while ready=0 is ignored, with no latching.
- SETUP: lasts DIR_SETUP cycles, then RUN. Define R = T+1+DIR_SETUP.
- RUN: tick counter k = 0..major-1, with tick k at cycle R+k*P.
  - On each tick, for each axis: s = acc_i + n_i. If s >= major, assert step[i], set acc_i = s - major and increment steps_out[i]; else acc_i = s.
  - Accumulator width is STEP_W+1 (no overflow).
  - Axis i emits exactly n_i pulses; the major axis steps every tick.
  - step[i] is high for PULSE_W cycles starting at the tick cycle.
  - After tick major-1, wait until R+major*P, then go to DONE.
- DONE: one cycle with done=1, then IDLE. ready=1 at the cycle after DONE.
  - Unpaused latency: done at T+1+DIR_SETUP+major*P.
  - major=0: done at T+1, ready at T+2.
- enable=0 (SETUP/RUN): period and setup counters freeze, and no new tick is issued. A step pulse already high completes its full PULSE_W, then stays low. Resuming continues the count exactly where it stopped; each low cycle adds one cycle of latency.
- abort=1 in SETUP/RUN: DONE on the next cycle with aborted=1. Any high step pulse is cut low at that edge. steps_out holds its partial counts. Abort in IDLE/DONE is ignored.
- abort and a tick in the same cycle: abort wins and the tick is not issued.
- dir changes only on new_in acceptance, never during a move.
- steps_out saturates implicitly, since the count is always <= n_i.

Test Plan:
1. NUM_AXES=2, DIR_SETUP=2, PULSE_W=2. num_steps={10,5}, P=4, new_in at T -> axis0 emits 10 pulses each 2 clk wide, starting at T+3 and every 4 clk. Axis1 steps on ticks 1,3,5,7,9. done at T+43. steps_out={10,5}.
2. num_steps={0,7}, direction=2'b10 -> dir=2'b10 at T+1. Axis1 emits 7 pulses, axis0 none. done at T+3+28.
3. num_steps={0,0} -> done at T+1, ready at T+2, no step pulses.
4. step_period=1, num_steps={3,3} -> P clamps to 4. Both axes pulse together at T+3, T+7 and T+11. done at T+15.
5. {10,5}, P=4: abort asserted at T+15 -> step forced low, done at T+16, aborted=1, steps_out={4,2}. A new_in during RUN before the abort is ignored.
6. enable low for 5 clk mid-period -> done delayed by exactly 5 clk and pulse counts unchanged. reset mid-RUN -> all outputs 0 and ready=1 on the next cycle.
